// File: rtl/uart_crc_rx_param.sv
// Oversampling UART receiver for frames of start, DATA_W data bits, CRC_W CRC bits and a
// stop bit. Each bit is decided by a 3-sample majority vote around the bit centre. The CRC
// is computed on the fly, checked against the received field, and the result is held in a
// valid/ready output stage.
module uart_crc_rx_param #(
  parameter int unsigned         CLK_FREQ  = 50000000,
  parameter int unsigned         BAUD_RATE = 9600,
  parameter int unsigned         OVS       = 16,
  parameter int unsigned         DATA_W    = 8,
  parameter int unsigned         CRC_W     = 8,
  parameter logic [CRC_W-1:0]    CRC_POLY  = CRC_W'(8'h07),
  parameter logic [CRC_W-1:0]    CRC_INIT  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_in,
  output logic [DATA_W-1:0] data_out,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_err,
  output logic              frame_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned DIV   = CLK_FREQ / (BAUD_RATE * OVS);
  localparam int unsigned DivW  = $clog2(DIV);
  localparam int unsigned SampW = $clog2(OVS);
  localparam int unsigned MaxW  = (DATA_W > CRC_W) ? DATA_W : CRC_W;
  localparam int unsigned BitW  = $clog2(MaxW) + 1;

  localparam logic [DivW-1:0]  DivLast  = DivW'(DIV - 1);
  localparam logic [SampW-1:0] SampLast = SampW'(OVS - 1);
  localparam logic [SampW-1:0] SampA    = SampW'(OVS / 2 - 1);
  localparam logic [SampW-1:0] SampB    = SampW'(OVS / 2);
  localparam logic [SampW-1:0] SampC    = SampW'(OVS / 2 + 1);
  localparam logic [BitW-1:0]  DataLast = BitW'(DATA_W - 1);
  localparam logic [BitW-1:0]  CrcLast  = BitW'(CRC_W - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StCrc, StStop} state_e;

  state_e              state_q, state_d;
  logic                rx_s1_q, rx_s2_q, rx_prev_q;
  logic [DivW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [SampW-1:0]    samp_cnt_q, samp_cnt_d;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [1:0]          smp_q, smp_d;
  logic [DATA_W-1:0]   data_sh_q, data_sh_d;
  logic [CRC_W-1:0]    crc_rx_q, crc_rx_d;
  logic [CRC_W-1:0]    crc_calc_q, crc_calc_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic [CRC_W-1:0]    crc_out_q, crc_out_d;
  logic                crc_err_q, crc_err_d;
  logic                frame_err_q, frame_err_d;
  logic                out_valid_q, out_valid_d;
  logic                overrun_q, overrun_d;

  logic                tick, decide, bit_end, fall, maj, fb, stop_decide;
  logic [SampW-1:0]    samp_nxt;

  // The sample counter value reached on a tick identifies the sample point.
  assign tick        = (state_q != StIdle) && (tick_cnt_q == DivLast);
  assign samp_nxt    = (samp_cnt_q == SampLast) ? '0 : samp_cnt_q + SampW'(1);
  assign decide      = tick && (samp_nxt == SampC);
  assign bit_end     = tick && (samp_nxt == SampLast);
  assign fall        = rx_prev_q & ~rx_s2_q;
  assign maj         = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s2_q) | (smp_q[1] & rx_s2_q);
  assign stop_decide = (state_q == StStop) && decide;

  // Two-flop synchroniser plus previous-value flop for start-edge detection; idle high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx_in;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // FSM, counters, shift registers and output stage state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      tick_cnt_q  <= '0;
      samp_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      smp_q       <= '0;
      data_sh_q   <= '0;
      crc_rx_q    <= '0;
      crc_calc_q  <= '0;
      data_out_q  <= '0;
      crc_out_q   <= '0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      samp_cnt_q  <= samp_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      smp_q       <= smp_d;
      data_sh_q   <= data_sh_d;
      crc_rx_q    <= crc_rx_d;
      crc_calc_q  <= crc_calc_d;
      data_out_q  <= data_out_d;
      crc_out_q   <= crc_out_d;
      crc_err_q   <= crc_err_d;
      frame_err_q <= frame_err_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state logic: bit timing, sampling, shifting and CRC accumulation.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    smp_d      = smp_q;
    data_sh_d  = data_sh_q;
    crc_rx_d   = crc_rx_q;
    crc_calc_d = crc_calc_q;
    fb         = 1'b0;

    if (state_q != StIdle) begin
      if (tick) begin
        tick_cnt_d = '0;
        samp_cnt_d = samp_nxt;
        if (samp_nxt == SampA) smp_d[0] = rx_s2_q;
        if (samp_nxt == SampB) smp_d[1] = rx_s2_q;
      end else begin
        tick_cnt_d = tick_cnt_q + DivW'(1);
      end
    end

    case (state_q)
      StIdle: begin
        tick_cnt_d = '0;
        samp_cnt_d = '0;
        if (fall) state_d = StStart;
      end
      StStart: begin
        if (decide) begin
          if (maj) state_d = StIdle;  // line back high at mid-bit: glitch
          else     crc_calc_d = CRC_INIT;
        end
        if (bit_end) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (decide) begin
          data_sh_d             = data_sh_q >> 1;
          data_sh_d[DATA_W-1]   = maj;
          fb                    = crc_calc_q[CRC_W-1] ^ maj;
          crc_calc_d            = (crc_calc_q << 1) ^ (fb ? CRC_POLY : '0);
        end
        if (bit_end) begin
          if (bit_cnt_q == DataLast) begin
            state_d   = StCrc;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      StCrc: begin
        if (decide) begin
          crc_rx_d            = crc_rx_q >> 1;
          crc_rx_d[CRC_W-1]   = maj;
        end
        if (bit_end) begin
          if (bit_cnt_q == CrcLast) begin
            state_d   = StStop;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      StStop: begin
        // Leave mid stop bit so a following start edge is not missed.
        if (decide) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output stage: load on stop decision unless an unaccepted result must be protected.
  always_comb begin
    data_out_d  = data_out_q;
    crc_out_d   = crc_out_q;
    crc_err_d   = crc_err_q;
    frame_err_d = frame_err_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;
    if (stop_decide) begin
      if (out_valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end else begin
        data_out_d  = data_sh_q;
        crc_out_d   = crc_rx_q;
        crc_err_d   = (crc_calc_q != crc_rx_q);
        frame_err_d = ~maj;
        out_valid_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign data_out  = data_out_q;
  assign crc_out   = crc_out_q;
  assign crc_err   = crc_err_q;
  assign frame_err = frame_err_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_crc_rx_param.sv
// Directed bench for uart_crc_rx_param: an 8/8 CRC-8 instance (DIV=4, OVS=8) and a
// 16/16 CRC-CCITT instance (DIV=2, OVS=8) share one clock and reset.
module tb_uart_crc_rx_param;

  localparam int unsigned Bclk8  = 32;  // OVS*DIV clocks per bit
  localparam int unsigned Bclk16 = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx8 = 1'b1, rx16 = 1'b1;
  logic        rdy8 = 1'b0, rdy16 = 1'b0;
  logic [7:0]  data8, crc8;
  logic [15:0] data16, crc16;
  logic        cerr8, ferr8, val8, ovr8, busy8;
  logic        cerr16, ferr16, val16, ovr16, busy16;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rise_cyc = 0;
  int start_cyc = 0;
  int ovr_cnt  = 0;
  logic val8_prev = 1'b0;

  uart_crc_rx_param #(
    .CLK_FREQ(32000), .BAUD_RATE(1000), .OVS(8), .DATA_W(8), .CRC_W(8),
    .CRC_POLY(8'h07), .CRC_INIT(8'h00)
  ) u_dut8 (
    .clk(clk), .reset(reset), .rx_in(rx8), .data_out(data8), .crc_out(crc8),
    .crc_err(cerr8), .frame_err(ferr8), .out_valid(val8), .out_ready(rdy8),
    .overrun(ovr8), .busy(busy8)
  );

  uart_crc_rx_param #(
    .CLK_FREQ(32000), .BAUD_RATE(2000), .OVS(8), .DATA_W(16), .CRC_W(16),
    .CRC_POLY(16'h1021), .CRC_INIT(16'hFFFF)
  ) u_dut16 (
    .clk(clk), .reset(reset), .rx_in(rx16), .data_out(data16), .crc_out(crc16),
    .crc_err(cerr16), .frame_err(ferr16), .out_valid(val16), .out_ready(rdy16),
    .overrun(ovr16), .busy(busy16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record out_valid rise time and count overrun cycles of the 8-bit instance.
  always @(negedge clk) begin
    if (val8 && !val8_prev) rise_cyc <= cyc;
    val8_prev <= val8;
    if (ovr8) ovr_cnt <= ovr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_gold(input logic [31:0] data, input int dw, input int cw,
                                           input logic [31:0] poly, input logic [31:0] init);
    logic [31:0] c, mask;
    logic        f;
    mask = (cw == 32) ? 32'hFFFF_FFFF : ((32'd1 << cw) - 32'd1);
    c    = init & mask;
    for (int i = 0; i < dw; i++) begin
      f = c[cw-1] ^ data[i];
      c = ((c << 1) ^ (f ? poly : 32'd0)) & mask;
    end
    return c;
  endfunction

  // Drive one full frame LSB-first, then return the line to idle.
  task automatic send_frame(input int sel, input logic [31:0] data, input logic [31:0] crc,
                            input logic stop, input int dw, input int cw, input int bclk);
    logic [63:0] fr;
    fr = '0;
    for (int i = 0; i < dw; i++) fr[1+i] = data[i];
    for (int i = 0; i < cw; i++) fr[1+dw+i] = crc[i];
    fr[1+dw+cw] = stop;
    for (int i = 0; i < dw + cw + 2; i++) begin
      @(negedge clk);
      if (i == 0) start_cyc = cyc;
      if (sel == 0) rx8 = fr[i];
      else          rx16 = fr[i];
      repeat (bclk - 1) @(negedge clk);
    end
    @(negedge clk);
    if (sel == 0) rx8 = 1'b1;
    else          rx16 = 1'b1;
  endtask

  task automatic accept8();
    @(negedge clk); rdy8 = 1'b1;
    @(negedge clk); rdy8 = 1'b0;
  endtask

  task automatic accept16();
    @(negedge clk); rdy16 = 1'b1;
    @(negedge clk); rdy16 = 1'b0;
  endtask

  initial begin
    logic [31:0] g, d, c;
    int          lat;

    // Reset state
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, val8}, 32'd0);
    chk("rst_data", {24'd0, data8}, 32'd0);
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_ovr", {31'd0, ovr8}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // 1: all-zero frame and latency
    send_frame(0, 32'h00, 32'h00, 1'b1, 8, 8, Bclk8);
    chk("t1_valid", {31'd0, val8}, 32'd1);
    chk("t1_data", {24'd0, data8}, 32'h00);
    chk("t1_cerr", {31'd0, cerr8}, 32'd0);
    chk("t1_ferr", {31'd0, ferr8}, 32'd0);
    lat = rise_cyc - start_cyc;
    chk("t1_latency_in_window", {31'd0, (lat >= 563 - 4) && (lat <= 563 + 4)}, 32'd1);
    accept8();
    chk("t1_valid_drop", {31'd0, val8}, 32'd0);

    // 2: 0xA5 with good CRC (0x72), then CRC bit 3 flipped
    send_frame(0, 32'hA5, 32'h72, 1'b1, 8, 8, Bclk8);
    chk("t2_data_good", {24'd0, data8}, 32'hA5);
    chk("t2_crc_good", {24'd0, crc8}, 32'h72);
    chk("t2_cerr_good", {31'd0, cerr8}, 32'd0);
    accept8();
    send_frame(0, 32'hA5, 32'h7A, 1'b1, 8, 8, Bclk8);
    chk("t2_data_bad", {24'd0, data8}, 32'hA5);
    chk("t2_crc_bad", {24'd0, crc8}, 32'h7A);
    chk("t2_cerr_bad", {31'd0, cerr8}, 32'd1);
    accept8();

    // 3: stop bit low, then a short glitch on the idle line
    g = crc_gold(32'h81, 8, 8, 32'h07, 32'h00);
    send_frame(0, 32'h81, g, 1'b0, 8, 8, Bclk8);
    chk("t3_valid", {31'd0, val8}, 32'd1);
    chk("t3_ferr", {31'd0, ferr8}, 32'd1);
    chk("t3_data", {24'd0, data8}, 32'h81);
    chk("t3_cerr", {31'd0, cerr8}, 32'd0);
    accept8();
    repeat (Bclk8) @(negedge clk);
    rx8 = 1'b0;
    repeat (6) @(negedge clk);
    chk("t3_glitch_busy", {31'd0, busy8}, 32'd1);
    repeat (6) @(negedge clk);
    rx8 = 1'b1;
    repeat (40) @(negedge clk);
    chk("t3_glitch_busy_low", {31'd0, busy8}, 32'd0);
    chk("t3_glitch_novalid", {31'd0, val8}, 32'd0);

    // 4: two frames with no acceptance -> hold first, single overrun pulse
    lat = ovr_cnt;
    send_frame(0, 32'h11, crc_gold(32'h11, 8, 8, 32'h07, 32'h00), 1'b1, 8, 8, Bclk8);
    send_frame(0, 32'h22, crc_gold(32'h22, 8, 8, 32'h07, 32'h00), 1'b1, 8, 8, Bclk8);
    chk("t4_ovr_cycles", ovr_cnt - lat, 32'd1);
    chk("t4_held_data", {24'd0, data8}, 32'h11);
    chk("t4_valid", {31'd0, val8}, 32'd1);
    chk("t4_ovr_now", {31'd0, ovr8}, 32'd0);
    @(negedge clk); rdy8 = 1'b1;
    @(negedge clk);
    chk("t4_valid_fall", {31'd0, val8}, 32'd0);
    rdy8 = 1'b0;

    // 5: reset during data bit 4, then a clean frame
    send_frame(0, 32'h5A, crc_gold(32'h5A, 8, 8, 32'h07, 32'h00), 1'b1, 8, 8, Bclk8);
    chk("t5_pre_valid", {31'd0, val8}, 32'd1);
    d = 32'h0F;  // start, d0..d3 then d4=0
    @(negedge clk); rx8 = 1'b0;
    repeat (Bclk8 - 1) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); rx8 = d[i];
      repeat (Bclk8 - 1) @(negedge clk);
    end
    @(negedge clk); rx8 = d[4];
    repeat (Bclk8 / 2) @(negedge clk);
    chk("t5_busy_mid", {31'd0, busy8}, 32'd1);
    reset = 1'b1;
    rx8 = 1'b1;
    @(negedge clk);
    chk("t5_rst_busy", {31'd0, busy8}, 32'd0);
    chk("t5_rst_valid", {31'd0, val8}, 32'd0);
    chk("t5_rst_data", {24'd0, data8}, 32'd0);
    chk("t5_rst_crc", {24'd0, crc8}, 32'd0);
    chk("t5_rst_flags", {29'd0, cerr8, ferr8, ovr8}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (64) @(negedge clk);
    send_frame(0, 32'h3C, crc_gold(32'h3C, 8, 8, 32'h07, 32'h00), 1'b1, 8, 8, Bclk8);
    chk("t5_valid", {31'd0, val8}, 32'd1);
    chk("t5_data", {24'd0, data8}, 32'h3C);
    chk("t5_cerr", {31'd0, cerr8}, 32'd0);
    chk("t5_ferr", {31'd0, ferr8}, 32'd0);
    accept8();

    // 6: CRC-CCITT instance, golden frame then 32 single-bit flips
    g = crc_gold(32'h1234, 16, 16, 32'h1021, 32'hFFFF);
    send_frame(1, 32'h1234, g, 1'b1, 16, 16, Bclk16);
    chk("t6_valid", {31'd0, val16}, 32'd1);
    chk("t6_data", {16'd0, data16}, 32'h1234);
    chk("t6_crc", {16'd0, crc16}, g);
    chk("t6_cerr", {31'd0, cerr16}, 32'd0);
    accept16();
    for (int f = 0; f < 32; f++) begin
      d = 32'h1234;
      c = g;
      if (f < 16) d[f] = ~d[f];
      else        c[f-16] = ~c[f-16];
      send_frame(1, d, c, 1'b1, 16, 16, Bclk16);
      chk($sformatf("t6_flip%0d_cerr", f), {31'd0, cerr16}, 32'd1);
      accept16();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
